// File: rtl/lc3_exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_exec_ctrl_pkg
// Brief    : Shared types and encodings for the LC-3 execution controller.
// Revision : 1.0 - initial release
// ============================================================================
package lc3_exec_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_RST, ST_F1, ST_F2, ST_F3, ST_DEC,
        ST_ALU, ST_BR, ST_NOP, ST_JMP, ST_JSR1, ST_JSR2,
        ST_MAR_ADDR, ST_IND_RD, ST_IND_MAR, ST_LD_RD, ST_LD_WB,
        ST_ST_MDR, ST_ST_WR, ST_LEA,
        ST_TRAP1, ST_TRAP2, ST_TRAP3, ST_TRAP4
    } state_t;

    localparam logic [3:0] c_OP_BR   = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_LD   = 4'b0010;
    localparam logic [3:0] c_OP_ST   = 4'b0011;
    localparam logic [3:0] c_OP_JSR  = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_LDR  = 4'b0110;
    localparam logic [3:0] c_OP_STR  = 4'b0111;
    localparam logic [3:0] c_OP_NOT  = 4'b1001;
    localparam logic [3:0] c_OP_LDI  = 4'b1010;
    localparam logic [3:0] c_OP_STI  = 4'b1011;
    localparam logic [3:0] c_OP_JMP  = 4'b1100;
    localparam logic [3:0] c_OP_LEA  = 4'b1110;
    localparam logic [3:0] c_OP_TRAP = 4'b1111;

    localparam logic [1:0] c_ALUK_ADD  = 2'b00;
    localparam logic [1:0] c_ALUK_AND  = 2'b01;
    localparam logic [1:0] c_ALUK_NOT  = 2'b10;
    localparam logic [1:0] c_ALUK_PASS = 2'b11;

    localparam logic [1:0] c_PCMUX_INC   = 2'b00;
    localparam logic [1:0] c_PCMUX_BUS   = 2'b01;
    localparam logic [1:0] c_PCMUX_ADDER = 2'b10;

    localparam logic       c_MARMUX_ZEXT = 1'b1;
    localparam logic       c_ADDR1_SR1   = 1'b0;
    localparam logic       c_ADDR1_PC    = 1'b1;

    localparam logic [1:0] c_ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] c_ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] c_ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] c_ADDR2_OFF11 = 2'b11;

    // bit1 = load MDR, bit0 = source (0 memory, 1 bus)
    localparam logic [1:0] c_LDMDR_MEM = 2'b10;
    localparam logic [1:0] c_LDMDR_BUS = 2'b11;

    typedef struct packed {
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic       ld_pc;
        logic       ld_ir;
        logic       ld_reg;
        logic       ld_cc;
        logic       ld_mar;
        logic [1:0] ld_mdr;
        logic       mem_rw;
        logic [1:0] pcmux;
        logic       marmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic       sr2mux;
        logic [1:0] aluk;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic [2:0] dr;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/lc3_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : lc3_alu_unit
// Brief    : Combinational 16-bit LC-3 ALU (ADD, AND, NOT A, PASS A).
// Revision : 1.0 - initial release
// ============================================================================
module lc3_alu_unit
    import lc3_exec_ctrl_pkg::*;
(
    input  logic [1:0]  i_aluk,
    input  logic [15:0] i_op_a,
    input  logic [15:0] i_op_b,
    output logic [15:0] o_result
);

    always_comb begin
        o_result = i_op_a;
        case (i_aluk)
            c_ALUK_ADD:  o_result = i_op_a + i_op_b;
            c_ALUK_AND:  o_result = i_op_a & i_op_b;
            c_ALUK_NOT:  o_result = ~i_op_a;
            c_ALUK_PASS: o_result = i_op_a;
            default:     o_result = i_op_a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lc3_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lc3_exec_ctrl
// Brief    : LC-3 Moore control FSM with ALU and address adder datapath.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_exec_ctrl
    import lc3_exec_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] INSTR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic [15:0] OP_A,
    input  logic [15:0] OP_B,
    output logic [15:0] ALU_RESULT,
    input  logic [15:0] ADDR_A,
    input  logic [15:0] ADDR_B,
    input  logic        CYI,
    output logic [15:0] ADDR_SUM,
    output logic        GATE_PC_SEL,
    output logic        GATE_MDR_SEL,
    output logic        GATE_ALU_SEL,
    output logic        GATE_MARMUX_SEL,
    output logic        LDPC,
    output logic        LDIR,
    output logic        LDREG,
    output logic        LDCC,
    output logic        LDMAR,
    output logic [1:0]  LDMDR,
    output logic        MEM_RW,
    output logic [1:0]  PCMUX_SEL,
    output logic        MARMUX_SEL,
    output logic        ADDR1MUX_SEL,
    output logic [1:0]  ADDR2MUX_SEL,
    output logic        SR2MUX_SEL,
    output logic [1:0]  ALUK,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [2:0]  DR
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  r_ctrl;

    function automatic state_t f_next(input state_t s, input logic [15:0] ir,
                                      input logic n, input logic z, input logic p);
        state_t     ns;
        logic [3:0] op;
        ns = ST_F1;
        op = ir[15:12];
        case (s)
            ST_F1:  ns = ST_F2;
            ST_F2:  ns = ST_F3;
            ST_F3:  ns = ST_DEC;
            ST_DEC: begin
                case (op)
                    c_OP_ADD, c_OP_AND, c_OP_NOT: ns = ST_ALU;
                    c_OP_BR:  ns = ((ir[11] & n) | (ir[10] & z) | (ir[9] & p)) ? ST_BR : ST_NOP;
                    c_OP_JMP: ns = ST_JMP;
                    c_OP_JSR: ns = ST_JSR1;
                    c_OP_LD, c_OP_LDR, c_OP_LDI,
                    c_OP_ST, c_OP_STR, c_OP_STI: ns = ST_MAR_ADDR;
                    c_OP_LEA:  ns = ST_LEA;
                    c_OP_TRAP: ns = ST_TRAP1;
                    default:   ns = ST_NOP;
                endcase
            end
            ST_MAR_ADDR: begin
                if (op == c_OP_LDI || op == c_OP_STI)      ns = ST_IND_RD;
                else if (op == c_OP_ST || op == c_OP_STR)  ns = ST_ST_MDR;
                else                                       ns = ST_LD_RD;
            end
            ST_IND_RD:  ns = ST_IND_MAR;
            ST_IND_MAR: ns = (op == c_OP_STI) ? ST_ST_MDR : ST_LD_RD;
            ST_LD_RD:   ns = ST_LD_WB;
            ST_ST_MDR:  ns = ST_ST_WR;
            ST_JSR1:    ns = ST_JSR2;
            ST_TRAP1:   ns = ST_TRAP2;
            ST_TRAP2:   ns = ST_TRAP3;
            ST_TRAP3:   ns = ST_TRAP4;
            default:    ns = ST_F1;
        endcase
        return ns;
    endfunction

    function automatic ctrl_t f_ctrl(input state_t s, input logic [15:0] ir);
        ctrl_t      c;
        logic [3:0] op;
        logic       is_store;
        c        = '0;
        op       = ir[15:12];
        is_store = (op == c_OP_ST) || (op == c_OP_STR) || (op == c_OP_STI);
        // Register-file fields are only presented once an instruction is executing
        if (!(s inside {ST_RST, ST_F1, ST_F2, ST_F3, ST_DEC})) begin
            c.sr1    = is_store ? ir[11:9] : ir[8:6];
            c.sr2    = ir[2:0];
            c.dr     = (op == c_OP_JSR || op == c_OP_TRAP) ? 3'b111 : ir[11:9];
            c.sr2mux = ir[5];
        end
        case (s)
            ST_F1:  begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = c_PCMUX_INC; end
            ST_F2:  c.ld_mdr = c_LDMDR_MEM;
            ST_F3:  begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
            ST_ALU: begin
                c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.aluk = (op == c_OP_AND) ? c_ALUK_AND : (op == c_OP_NOT) ? c_ALUK_NOT : c_ALUK_ADD;
            end
            ST_BR:  begin c.ld_pc = 1'b1; c.pcmux = c_PCMUX_ADDER; c.addr1mux = c_ADDR1_PC; c.addr2mux = c_ADDR2_OFF9; end
            ST_JMP: begin c.ld_pc = 1'b1; c.pcmux = c_PCMUX_ADDER; c.addr1mux = c_ADDR1_SR1; c.addr2mux = c_ADDR2_ZERO; end
            ST_JSR1: begin c.gate_pc = 1'b1; c.ld_reg = 1'b1; end
            ST_JSR2: begin
                c.ld_pc = 1'b1; c.pcmux = c_PCMUX_ADDER;
                c.addr1mux = ir[11] ? c_ADDR1_PC : c_ADDR1_SR1;
                c.addr2mux = ir[11] ? c_ADDR2_OFF11 : c_ADDR2_ZERO;
            end
            ST_MAR_ADDR: begin
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
                c.addr1mux = (op == c_OP_LDR || op == c_OP_STR) ? c_ADDR1_SR1 : c_ADDR1_PC;
                c.addr2mux = (op == c_OP_LDR || op == c_OP_STR) ? c_ADDR2_OFF6 : c_ADDR2_OFF9;
            end
            ST_IND_RD, ST_LD_RD, ST_TRAP3: c.ld_mdr = c_LDMDR_MEM;
            ST_IND_MAR: begin c.gate_mdr = 1'b1; c.ld_mar = 1'b1; end
            ST_LD_WB:   begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
            ST_ST_MDR:  begin c.gate_alu = 1'b1; c.aluk = c_ALUK_PASS; c.ld_mdr = c_LDMDR_BUS; end
            ST_ST_WR:   c.mem_rw = 1'b1;
            ST_LEA: begin
                c.gate_marmux = 1'b1; c.ld_reg = 1'b1;
                c.addr1mux = c_ADDR1_PC; c.addr2mux = c_ADDR2_OFF9;
            end
            ST_TRAP1: begin c.gate_pc = 1'b1; c.ld_reg = 1'b1; end
            ST_TRAP2: begin c.gate_marmux = 1'b1; c.ld_mar = 1'b1; c.marmux = c_MARMUX_ZEXT; end
            ST_TRAP4: begin c.gate_mdr = 1'b1; c.ld_pc = 1'b1; c.pcmux = c_PCMUX_BUS; end
            default: ;
        endcase
        return c;
    endfunction

    assign w_next_state = f_next(r_state, INSTR, N, Z, P);

    // Outputs are registered alongside the state so they line up with it
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= ST_RST;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= f_ctrl(w_next_state, INSTR);
        end
    end

    lc3_alu_unit u_alu (
        .i_aluk   (r_ctrl.aluk),
        .i_op_a   (OP_A),
        .i_op_b   (OP_B),
        .o_result (ALU_RESULT)
    );

    assign ADDR_SUM = ADDR_A + ADDR_B + {15'd0, CYI};

    assign GATE_PC_SEL     = r_ctrl.gate_pc;
    assign GATE_MDR_SEL    = r_ctrl.gate_mdr;
    assign GATE_ALU_SEL    = r_ctrl.gate_alu;
    assign GATE_MARMUX_SEL = r_ctrl.gate_marmux;
    assign LDPC            = r_ctrl.ld_pc;
    assign LDIR            = r_ctrl.ld_ir;
    assign LDREG           = r_ctrl.ld_reg;
    assign LDCC            = r_ctrl.ld_cc;
    assign LDMAR           = r_ctrl.ld_mar;
    assign LDMDR           = r_ctrl.ld_mdr;
    assign MEM_RW          = r_ctrl.mem_rw;
    assign PCMUX_SEL       = r_ctrl.pcmux;
    assign MARMUX_SEL      = r_ctrl.marmux;
    assign ADDR1MUX_SEL    = r_ctrl.addr1mux;
    assign ADDR2MUX_SEL    = r_ctrl.addr2mux;
    assign SR2MUX_SEL      = r_ctrl.sr2mux;
    assign ALUK            = r_ctrl.aluk;
    assign SR1             = r_ctrl.sr1;
    assign SR2             = r_ctrl.sr2;
    assign DR              = r_ctrl.dr;

endmodule
`default_nettype wire

// File: tb/tb_lc3_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_exec_ctrl
// Brief    : Directed self-checking bench for lc3_exec_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_exec_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] INSTR;
    logic        N, Z, P;
    logic [15:0] OP_A, OP_B, ALU_RESULT;
    logic [15:0] ADDR_A, ADDR_B, ADDR_SUM;
    logic        CYI;
    logic        GATE_PC_SEL, GATE_MDR_SEL, GATE_ALU_SEL, GATE_MARMUX_SEL;
    logic        LDPC, LDIR, LDREG, LDCC, LDMAR, MEM_RW;
    logic [1:0]  LDMDR, PCMUX_SEL, ADDR2MUX_SEL, ALUK;
    logic        MARMUX_SEL, ADDR1MUX_SEL, SR2MUX_SEL;
    logic [2:0]  SR1, SR2, DR;

    int n_checks = 0;
    int n_fail   = 0;

    logic [29:0] ctl;
    logic [29:0] exp_ctl;

    assign ctl = {GATE_PC_SEL, GATE_MDR_SEL, GATE_ALU_SEL, GATE_MARMUX_SEL,
                  LDPC, LDIR, LDREG, LDCC, LDMAR, LDMDR, MEM_RW, PCMUX_SEL,
                  MARMUX_SEL, ADDR1MUX_SEL, ADDR2MUX_SEL, SR2MUX_SEL, ALUK,
                  SR1, SR2, DR};

    lc3_exec_ctrl dut (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .N(N), .Z(Z), .P(P),
        .OP_A(OP_A), .OP_B(OP_B), .ALU_RESULT(ALU_RESULT),
        .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .CYI(CYI), .ADDR_SUM(ADDR_SUM),
        .GATE_PC_SEL(GATE_PC_SEL), .GATE_MDR_SEL(GATE_MDR_SEL),
        .GATE_ALU_SEL(GATE_ALU_SEL), .GATE_MARMUX_SEL(GATE_MARMUX_SEL),
        .LDPC(LDPC), .LDIR(LDIR), .LDREG(LDREG), .LDCC(LDCC), .LDMAR(LDMAR),
        .LDMDR(LDMDR), .MEM_RW(MEM_RW), .PCMUX_SEL(PCMUX_SEL),
        .MARMUX_SEL(MARMUX_SEL), .ADDR1MUX_SEL(ADDR1MUX_SEL),
        .ADDR2MUX_SEL(ADDR2MUX_SEL), .SR2MUX_SEL(SR2MUX_SEL), .ALUK(ALUK),
        .SR1(SR1), .SR2(SR2), .DR(DR)
    );

    always #5 CLK = ~CLK;

    // Builds an expected control word in the same bit order as ctl
    function automatic logic [29:0] mk(
        input logic [3:0] g, input logic [4:0] ld, input logic [1:0] ldmdr,
        input logic memrw, input logic [1:0] pcmux, input logic marmux,
        input logic a1, input logic [1:0] a2, input logic sr2m,
        input logic [1:0] aluk, input logic [2:0] sr1, input logic [2:0] sr2,
        input logic [2:0] dr);
        return {g, ld, ldmdr, memrw, pcmux, marmux, a1, a2, sr2m, aluk, sr1, sr2, dr};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // From a state whose successor is F1: fetch, decode, land on first execute state
    task automatic goto_exec(input logic [15:0] ir);
        INSTR = ir;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ctl !== 30'd0) begin n_fail++; $display("FAIL reset_ctl: got %h expected %h", ctl, 30'd0); end
        OP_A = 16'hFFFF; OP_B = 16'h0002;
        #1;
        n_checks++;
        if (ALU_RESULT !== 16'h0001) begin n_fail++; $display("FAIL alu_add_wrap: got %h expected %h", ALU_RESULT, 16'h0001); end
    endtask

    task automatic test_adder();
        ADDR_A = 16'h7FFF; ADDR_B = 16'h0001; CYI = 1'b0; #1;
        n_checks++;
        if (ADDR_SUM !== 16'h8000) begin n_fail++; $display("FAIL adder_7fff: got %h expected %h", ADDR_SUM, 16'h8000); end
        ADDR_A = 16'hFFFF; ADDR_B = 16'h0000; CYI = 1'b1; #1;
        n_checks++;
        if (ADDR_SUM !== 16'h0000) begin n_fail++; $display("FAIL adder_cyi_wrap: got %h expected %h", ADDR_SUM, 16'h0000); end
        ADDR_A = 16'h1234; ADDR_B = 16'h1111; CYI = 1'b1; #1;
        n_checks++;
        if (ADDR_SUM !== 16'h2346) begin n_fail++; $display("FAIL adder_generic: got %h expected %h", ADDR_SUM, 16'h2346); end
    endtask

    task automatic test_fetch();
        INSTR = 16'h1263;
        RESET = 1'b1;
        tick();
        exp_ctl = mk(4'b1000, 5'b10001, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 3'd0, 3'd0, 3'd0);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL fetch_f1: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0000, 5'b00000, 2'b10, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 3'd0, 3'd0, 3'd0);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL fetch_f2: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0100, 5'b01000, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 3'd0, 3'd0, 3'd0);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL fetch_f3: got %h expected %h", ctl, exp_ctl); end
        tick();
        n_checks++;
        if (ctl !== 30'd0) begin n_fail++; $display("FAIL decode_idle: got %h expected %h", ctl, 30'd0); end
    endtask

    task automatic test_add();
        tick();
        exp_ctl = mk(4'b0010, 5'b00110, 2'b00, 0, 2'b00, 0, 0, 2'b00, 1, 2'b00, 3'd1, 3'd3, 3'd1);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL add_exec: got %h expected %h", ctl, exp_ctl); end
        OP_A = 16'h7FFF; OP_B = 16'h0001; #1;
        n_checks++;
        if (ALU_RESULT !== 16'h8000) begin n_fail++; $display("FAIL add_result: got %h expected %h", ALU_RESULT, 16'h8000); end
    endtask

    task automatic test_not();
        goto_exec(16'h927F);
        exp_ctl = mk(4'b0010, 5'b00110, 2'b00, 0, 2'b00, 0, 0, 2'b00, 1, 2'b10, 3'd1, 3'd7, 3'd1);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL not_exec: got %h expected %h", ctl, exp_ctl); end
        OP_A = 16'h00F0; OP_B = 16'h1234; #1;
        n_checks++;
        if (ALU_RESULT !== 16'hFF0F) begin n_fail++; $display("FAIL not_result: got %h expected %h", ALU_RESULT, 16'hFF0F); end
    endtask

    task automatic test_and();
        goto_exec(16'h5042);
        exp_ctl = mk(4'b0010, 5'b00110, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 3'd1, 3'd2, 3'd0);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL and_exec: got %h expected %h", ctl, exp_ctl); end
        OP_A = 16'hF0F0; OP_B = 16'h3C3C; #1;
        n_checks++;
        if (ALU_RESULT !== 16'h3030) begin n_fail++; $display("FAIL and_result: got %h expected %h", ALU_RESULT, 16'h3030); end
    endtask

    task automatic test_br();
        N = 1'b0; Z = 1'b1; P = 1'b0;
        goto_exec(16'h0402);
        exp_ctl = mk(4'b0000, 5'b10000, 2'b00, 0, 2'b10, 0, 1, 2'b10, 0, 2'b00, 3'd0, 3'd2, 3'd2);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL br_taken: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b1000, 5'b10001, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 3'd0, 3'd0, 3'd0);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL br_return_f1: got %h expected %h", ctl, exp_ctl); end
        Z = 1'b0; N = 1'b1; P = 1'b1;
        repeat (4) tick();
        exp_ctl = mk(4'b0000, 5'b00000, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 3'd0, 3'd2, 3'd2);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL br_not_taken: got %h expected %h", ctl, exp_ctl); end
    endtask

    task automatic test_ldr();
        goto_exec(16'h6A85);
        exp_ctl = mk(4'b0001, 5'b00001, 2'b00, 0, 2'b00, 0, 0, 2'b01, 0, 2'b00, 3'd2, 3'd5, 3'd5);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL ldr_mar: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0000, 5'b00000, 2'b10, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 3'd2, 3'd5, 3'd5);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL ldr_mdr: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0100, 5'b00110, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 3'd2, 3'd5, 3'd5);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL ldr_wb: got %h expected %h", ctl, exp_ctl); end
    endtask

    task automatic test_sti();
        goto_exec(16'hB5FE);
        exp_ctl = mk(4'b0001, 5'b00001, 2'b00, 0, 2'b00, 0, 1, 2'b10, 1, 2'b00, 3'd2, 3'd6, 3'd2);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL sti_mar: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0000, 5'b00000, 2'b10, 0, 2'b00, 0, 0, 2'b00, 1, 2'b00, 3'd2, 3'd6, 3'd2);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL sti_ind_rd: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0100, 5'b00001, 2'b00, 0, 2'b00, 0, 0, 2'b00, 1, 2'b00, 3'd2, 3'd6, 3'd2);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL sti_ind_mar: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0010, 5'b00000, 2'b11, 0, 2'b00, 0, 0, 2'b00, 1, 2'b11, 3'd2, 3'd6, 3'd2);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL sti_mdr: got %h expected %h", ctl, exp_ctl); end
        OP_A = 16'hBEEF; OP_B = 16'h0101; #1;
        n_checks++;
        if (ALU_RESULT !== 16'hBEEF) begin n_fail++; $display("FAIL pass_result: got %h expected %h", ALU_RESULT, 16'hBEEF); end
        tick();
        exp_ctl = mk(4'b0000, 5'b00000, 2'b00, 1, 2'b00, 0, 0, 2'b00, 1, 2'b00, 3'd2, 3'd6, 3'd2);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL sti_write: got %h expected %h", ctl, exp_ctl); end
    endtask

    task automatic test_jsr();
        goto_exec(16'h4805);
        exp_ctl = mk(4'b1000, 5'b00100, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 3'd0, 3'd5, 3'd7);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL jsr_link: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0000, 5'b10000, 2'b00, 0, 2'b10, 0, 1, 2'b11, 0, 2'b00, 3'd0, 3'd5, 3'd7);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL jsr_jump: got %h expected %h", ctl, exp_ctl); end
    endtask

    task automatic test_trap();
        goto_exec(16'hF025);
        exp_ctl = mk(4'b1000, 5'b00100, 2'b00, 0, 2'b00, 0, 0, 2'b00, 1, 2'b00, 3'd0, 3'd5, 3'd7);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL trap_link: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0001, 5'b00001, 2'b00, 0, 2'b00, 1, 0, 2'b00, 1, 2'b00, 3'd0, 3'd5, 3'd7);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL trap_mar: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0000, 5'b00000, 2'b10, 0, 2'b00, 0, 0, 2'b00, 1, 2'b00, 3'd0, 3'd5, 3'd7);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL trap_mdr: got %h expected %h", ctl, exp_ctl); end
        tick();
        exp_ctl = mk(4'b0100, 5'b10000, 2'b00, 0, 2'b01, 0, 0, 2'b00, 1, 2'b00, 3'd0, 3'd5, 3'd7);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL trap_pc: got %h expected %h", ctl, exp_ctl); end
    endtask

    task automatic test_reset_mid();
        goto_exec(16'hF025);
        tick();
        RESET = 1'b0;
        tick();
        n_checks++;
        if (ctl !== 30'd0) begin n_fail++; $display("FAIL reset_mid_ctl: got %h expected %h", ctl, 30'd0); end
        RESET = 1'b1;
        tick();
        exp_ctl = mk(4'b1000, 5'b10001, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 3'd0, 3'd0, 3'd0);
        n_checks++;
        if (ctl !== exp_ctl) begin n_fail++; $display("FAIL reset_mid_f1: got %h expected %h", ctl, exp_ctl); end
    endtask

    initial begin
        RESET = 1'b0; INSTR = 16'h0000; N = 1'b0; Z = 1'b0; P = 1'b0;
        OP_A = 16'h0000; OP_B = 16'h0000;
        ADDR_A = 16'h0000; ADDR_B = 16'h0000; CYI = 1'b0;
        test_reset();
        test_adder();
        test_fetch();
        test_add();
        test_not();
        test_and();
        test_br();
        test_ldr();
        test_sti();
        test_jsr();
        test_trap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lc3_exec_ctrl.md
LC3_EXEC_CTRL -- requirements
Module: lc3_exec_ctrl

Interface
REQ-001 Parameters: none; data width fixed at 16.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RESET  in  1  synchronous, active-low reset (asserted when 0).
REQ-004 INSTR  in  16  current IR contents; N, Z, P  in  1 each  condition-code flags.
REQ-005 OP_A, OP_B  in  16  ALU operands; ALU_RESULT  out  16  combinational ALU output.
REQ-006 ADDR_A, ADDR_B  in  16  address-adder operands; CYI  in  1  carry-in; ADDR_SUM  out  16  sum.
REQ-007 GATE_PC_SEL, GATE_MDR_SEL, GATE_ALU_SEL, GATE_MARMUX_SEL  out  1 each  bus drivers; at most one high per cycle.
REQ-008 LDPC, LDIR, LDREG, LDCC, LDMAR  out  1 each  register load enables.
REQ-009 LDMDR  out  2  bit1 = MDR load, bit0 = MDR source (0 memory, 1 bus); MEM_RW  out  1  1 = write MDR to M[MAR].
REQ-010 PCMUX_SEL  out  2  00 PC+1, 01 bus, 10 address adder; MARMUX_SEL  out  1  0 adder, 1 ZEXT(IR[7:0]).
REQ-011 ADDR1MUX_SEL  out  1  0 SR1, 1 PC; ADDR2MUX_SEL  out  2  00 zero, 01 SEXT(IR[5:0]), 10 SEXT(IR[8:0]), 11 SEXT(IR[10:0]).
REQ-012 SR2MUX_SEL  out  1  0 SR2, 1 SEXT(IR[4:0]); ALUK  out  2  00 ADD, 01 AND, 10 NOT A, 11 PASS A.
REQ-013 SR1, SR2, DR  out  3 each  register-file addresses.

Function
REQ-014 ALU_RESULT per ALUK: OP_A+OP_B mod 2^16, OP_A&OP_B, ~OP_A, OP_A; purely combinational.
REQ-015 ADDR_SUM = ADDR_A+ADDR_B+CYI mod 2^16, carry-out discarded, combinational.
REQ-016 Moore FSM; outputs decoded from state and INSTR only; all unlisted outputs 0 in every state.
REQ-017 Fetch: F1 GATE_PC, LDMAR, LDPC, PCMUX=00; F2 LDMDR=10; F3 GATE_MDR, LDIR; then DECODE (no outputs) -> state by INSTR[15:12].
REQ-018 Field decode: SR1=INSTR[8:6] (stores: INSTR[11:9]), SR2=INSTR[2:0], DR=INSTR[11:9] (JSR/JSRR/TRAP: 3'b111), SR2MUX_SEL=INSTR[5].
REQ-019 ADD(0001)/AND(0101)/NOT(1001): one state GATE_ALU, LDREG, LDCC, ALUK 00/01/10 -> F1.
REQ-020 BR(0000): if (IR11&N)|(IR10&Z)|(IR9&P) one state LDPC, PCMUX=10, ADDR1=1, ADDR2=10; else no-op; -> F1.
REQ-021 JMP(1100): LDPC, PCMUX=10, ADDR1=0, ADDR2=00 -> F1.
REQ-022 JSR/JSRR(0100): S1 GATE_PC, LDREG (R7); S2 LDPC, PCMUX=10, IR[11]=1 ADDR1=1/ADDR2=11 else ADDR1=0/ADDR2=00; -> F1.
REQ-023 LD(0010)/LDR(0110): MAR<-adder (GATE_MARMUX, LDMAR; LD ADDR1=1/ADDR2=10, LDR ADDR1=0/ADDR2=01); MDR<-M; DR<-MDR with LDCC.
REQ-024 LDI(1010): as LD plus extra MAR<-MDR (GATE_MDR, LDMAR) and MDR<-M before final load.
REQ-025 LEA(1110): one state GATE_MARMUX, LDREG, ADDR1=1, ADDR2=10, no LDCC.
REQ-026 ST(0011)/STR(0111)/STI(1011): MAR<-address (STI via indirection as REQ-024); MDR<-SR via ALUK=11, GATE_ALU, LDMDR=11; then MEM_RW=1 one cycle -> F1.
REQ-027 TRAP(1111): R7<-PC; MAR<-ZEXT (MARMUX=1); MDR<-M; PC<-MDR (GATE_MDR, LDPC, PCMUX=01) -> F1.
REQ-028 RTI(1000), reserved(1101): no-op state -> F1.
REQ-029 Each memory access one cycle; 16-bit operations wrap silently (0x7FFF+1=0x8000).

Reset
REQ-030 RESET=0 at rising edge: state <= RST, all control outputs 0 that cycle; reset mid-instruction abandons it.
REQ-031 First edge with RESET=1 moves RST -> F1; ALU/adder unaffected by reset.

Structure
REQ-032 Shared package: state enum, opcode constants, ALUK and mux-select encodings.
REQ-033 One sub-module lc3_alu_unit (ALU); adder and FSM inline.

Verification
REQ-034 ALUK=00, OP_A=0xFFFF, OP_B=0x0002 -> 0x0001; ALUK=10, OP_A=0x00F0 -> 0xFF0F.
REQ-035 ADDR 0x7FFF+0x0001, CYI=0 -> 0x8000; 0xFFFF+0x0000, CYI=1 -> 0x0000.
REQ-036 Reset release -> F1 next cycle: GATE_PC=1, LDMAR=1, LDPC=1; F2 LDMDR=10; F3 LDIR=1.
REQ-037 INSTR=0x1263 (ADD R1,R1,#3) -> execute cycle SR1=1, DR=1, SR2MUX=1, GATE_ALU, LDREG, LDCC.
REQ-038 INSTR=0x0402 (BRz), Z=1 -> LDPC, PCMUX=10, ADDR2=10; Z=0 -> no LDPC.
REQ-039 INSTR=0xF025 (TRAP) -> DR=7 with GATE_PC, then MARMUX=1 LDMAR, then LDPC PCMUX=01.
